// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one byte to the keyboard and reports ACK (tx_done) or failure (tx_err).
// The pins are open drain: each *_oe = 1 pulls that line low, and the top level builds the tristates.
//
// Handshake: tx_start is a one-cycle request and needs no ready signal.
// The request is taken only when tx_busy is 0; at any other time it is dropped, not queued.
// tx_busy rises in the cycle after acceptance.
// tx_busy falls in the same cycle that tx_done or tx_err pulses.
//
// The FSM state is held in the named register `state` so that checkers can bind to it.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2k_clk_in,
  input  logic       ps2k_data_in,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       ps2k_clk_oe,
  output logic       ps2k_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t          state, state_n;
  logic            clk_s1, clk_s2, dat_s1, dat_s2;
  logic            clk_f, clk_f_d;
  logic [FW-1:0]   flt_cnt;
  logic            fe;
  logic [IW-1:0]   inh_cnt, inh_cnt_n;
  logic [TW-1:0]   to_cnt, to_cnt_n;
  logic [3:0]      bit_idx, bit_idx_n;
  logic [8:0]      shift, shift_n;
  logic            data_oe_q, data_oe_n;
  logic            done_q, done_n, err_q, err_n;
  logic            timed_out;

  // Synchronise both pins and debounce the clock: clk_f moves only after FILTER_LEN equal samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      clk_f   <= 1'b1;
      clk_f_d <= 1'b1;
      flt_cnt <= '0;
    end else begin
      clk_s1  <= ps2k_clk_in;
      clk_s2  <= clk_s1;
      dat_s1  <= ps2k_data_in;
      dat_s2  <= dat_s1;
      clk_f_d <= clk_f;
      if (clk_s2 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_f   <= clk_s2;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fe = clk_f_d & ~clk_f;

  // State and datapath registers; reset releases both lines at the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      inh_cnt   <= inh_cnt_n;
      to_cnt    <= to_cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      data_oe_q <= data_oe_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  // Next-state logic; the shift register moves right so each device falling edge presents bit 0.
  always_comb begin
    state_n   = state;
    inh_cnt_n = inh_cnt;
    to_cnt_n  = to_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    data_oe_n = data_oe_q;
    done_n    = 1'b0;
    err_n     = 1'b0;
    timed_out = (to_cnt == TO_LAST);
    case (state)
      S_IDLE: begin
        data_oe_n = 1'b0;
        if (tx_start) begin
          shift_n   = {~^tx_byte, tx_byte};
          inh_cnt_n = '0;
          state_n   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt == INH_LAST) begin
          data_oe_n = 1'b1;
          state_n   = S_REQ;
        end else begin
          inh_cnt_n = inh_cnt + 1'b1;
        end
      end
      S_REQ: begin
        to_cnt_n  = '0;
        bit_idx_n = '0;
        state_n   = S_SEND;
      end
      S_SEND: begin
        if (fe) begin
          to_cnt_n = '0;
          if (bit_idx == 4'd9) begin
            data_oe_n = 1'b0;
            state_n   = S_ACK;
          end else begin
            data_oe_n = ~shift[0];
            shift_n   = {1'b0, shift[8:1]};
            bit_idx_n = bit_idx + 1'b1;
          end
        end else if (timed_out) begin
          data_oe_n = 1'b0;
          err_n     = 1'b1;
          state_n   = S_IDLE;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      S_ACK: begin
        if (fe) begin
          to_cnt_n = '0;
          if (!dat_s2) begin
            state_n = S_WAIT_IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end else if (timed_out) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_f && dat_s2) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (fe) begin
          to_cnt_n = '0;
        end else if (timed_out) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      default: begin
        data_oe_n = 1'b0;
        state_n   = S_IDLE;
      end
    endcase
  end

  assign ps2k_clk_oe  = (state == S_INHIBIT) || (state == S_REQ);
  assign ps2k_data_oe = data_oe_q;
  assign tx_busy      = (state != S_IDLE);
  assign tx_done      = done_q;
  assign tx_err       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx.
// A simple keyboard model clocks the bus with an 80-cycle period and can ACK, NACK, stay silent or glitch the clock.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 300;
  localparam int HALF = 40;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_byte  = 8'h00;
  logic       ps2k_clk_in, ps2k_data_in;
  logic       ps2k_clk_oe, ps2k_data_oe, tx_busy, tx_done, tx_err;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  logic [0:0] exp_q[$];

  // Wired-AND open-drain bus: the host or the device can pull a line low.
  assign ps2k_clk_in  = dev_clk & ~ps2k_clk_oe;
  assign ps2k_data_in = dev_data & ~ps2k_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2k_clk_in(ps2k_clk_in),
    .ps2k_data_in(ps2k_data_in),
    .tx_byte(tx_byte),
    .tx_start(tx_start),
    .ps2k_clk_oe(ps2k_clk_oe),
    .ps2k_data_oe(ps2k_data_oe),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_err(tx_err)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  // Pulse monitor for the completion strobes.
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_err) err_cnt++;
    if (tx_done && tx_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue a request and follow it through INHIBIT and REQ into the first SEND cycle.
  task automatic start_req(input logic [7:0] b);
    int n;
    @(negedge clk);
    tx_byte  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("busy_after_start", 32'(tx_busy), 32'd1);
    n = 0;
    while (ps2k_clk_oe && !ps2k_data_oe && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", 32'(n), 32'(INH));
    check("req_lines", 32'({ps2k_clk_oe, ps2k_data_oe}), 32'b11);
    @(negedge clk);
    check("send_entry_lines", 32'({ps2k_clk_oe, ps2k_data_oe}), 32'b01);
  endtask

  // Run one full transfer with the device model.
  // ack: device pulls data low at fe11. glitch: 2-cycle clock dips in the high phases.
  // poke: a tx_start for 0x55 while SEND is in progress.
  task automatic run_xfer(input logic [7:0] b, input bit ack, input bit glitch, input bit poke);
    logic [8:0] sh;
    logic [0:0] exp_bit;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    sh = {~^b, b};
    for (int i = 0; i < 9; i++) exp_q.push_back(~sh[i]);
    exp_q.push_back(1'b0);
    start_req(b);
    repeat (10) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) dev_data = ~ack;
      dev_clk = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      if (k <= 10) begin
        exp_bit = exp_q.pop_front();
        check($sformatf("byte%02h_fe%0d_data_oe", b, k), 32'(ps2k_data_oe), 32'(exp_bit));
      end
      repeat (HALF / 2) @(negedge clk);
      dev_clk = 1'b1;
      if (k == 11) dev_data = 1'b1;
      if (glitch && k >= 2 && k <= 8) begin
        repeat (10) @(negedge clk);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 12) @(negedge clk);
      end else if (poke && k == 3) begin
        repeat (10) @(negedge clk);
        tx_byte  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (HALF - 11) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    repeat (5) @(negedge clk);
    check($sformatf("byte%02h_done_pulses", b), 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    check($sformatf("byte%02h_err_pulses", b), 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
    check($sformatf("byte%02h_idle_outputs", b), 32'({tx_busy, ps2k_clk_oe, ps2k_data_oe}), 32'd0);
  endtask

  // Stimulus.
  initial begin
    int n, d0, e0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({ps2k_clk_oe, ps2k_data_oe, tx_busy, tx_done, tx_err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Set-LEDs command, then the two parity corner bytes.
    run_xfer(8'hED, 1'b1, 1'b0, 1'b0);
    run_xfer(8'h00, 1'b1, 1'b0, 1'b0);
    run_xfer(8'h01, 1'b1, 1'b0, 1'b0);

    // Device does not ACK.
    run_xfer(8'h3C, 1'b0, 1'b0, 1'b0);

    // Device never clocks after the request.
    d0 = done_cnt;
    e0 = err_cnt;
    start_req(8'hA5);
    n = 0;
    while (!tx_err && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TO));
    check("timeout_lines", 32'({tx_busy, ps2k_clk_oe, ps2k_data_oe}), 32'd0);
    @(negedge clk);
    check("timeout_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("timeout_done_pulses", 32'(done_cnt - d0), 32'd0);

    // A request that arrives during SEND is ignored.
    run_xfer(8'hED, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of SEND, with a coincident tx_start.
    start_req(8'hED);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    check("pre_reset_data_oe", 32'(ps2k_data_oe), 32'd1);
    exp_q.delete();
    rst      = 1'b1;
    tx_start = 1'b1;
    @(negedge clk);
    check("reset_mid_send_lines", 32'({tx_busy, ps2k_clk_oe, ps2k_data_oe}), 32'd0);
    rst      = 1'b0;
    tx_start = 1'b0;
    @(negedge clk);
    check("start_with_rst_ignored", 32'(tx_busy), 32'd0);
    run_xfer(8'hFF, 1'b1, 1'b0, 1'b0);

    // Short clock glitches must not add falling edges.
    run_xfer(8'hA7, 1'b1, 1'b1, 1'b0);

    check("done_err_overlap", 32'(both_cnt), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
